// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline slice.
// Holds the 6-bit ALU control codes used on id_alu_ctr/ex_alu_ctr
// and the operand forward-select enumeration.
package id_ex_stage_pkg;

  // R-type ALU operations (funct encodings)
  localparam logic [5:0] ALU_ADD   = 6'b100000;
  localparam logic [5:0] ALU_ADDU  = 6'b100001;
  localparam logic [5:0] ALU_SUB   = 6'b100010;
  localparam logic [5:0] ALU_SUBU  = 6'b100011;
  localparam logic [5:0] ALU_AND   = 6'b100100;
  localparam logic [5:0] ALU_OR    = 6'b100101;
  localparam logic [5:0] ALU_XOR   = 6'b100110;
  localparam logic [5:0] ALU_NOR   = 6'b100111;
  localparam logic [5:0] ALU_SLT   = 6'b101010;
  localparam logic [5:0] ALU_SLTU  = 6'b101011;
  localparam logic [5:0] ALU_SLL   = 6'b000000;
  localparam logic [5:0] ALU_SRL   = 6'b000010;
  localparam logic [5:0] ALU_SRA   = 6'b000011;

  // I-type ALU operations (opcode encodings)
  localparam logic [5:0] ALU_ADDI  = 6'b001000;
  localparam logic [5:0] ALU_ADDIU = 6'b001001;
  localparam logic [5:0] ALU_SLTI  = 6'b001010;
  localparam logic [5:0] ALU_SLTIU = 6'b001011;
  localparam logic [5:0] ALU_ANDI  = 6'b001100;
  localparam logic [5:0] ALU_ORI   = 6'b001101;
  localparam logic [5:0] ALU_XORI  = 6'b001110;

  // Source of a forwarded operand
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// ex_fwd_unit: combinational operand forwarding for the EX stage.
// Ports:
//   rs_addr/rt_addr, rs_data/rt_data : registered EX source numbers and read data
//   mem_*  : EX/MEM producer (write enable, destination, value)
//   wb_*   : MEM/WB producer (write enable, destination, value)
//   rs_fwd/rt_fwd : forwarded operand values
// The younger MEM producer wins over WB; register 0 is never forwarded.
import id_ex_stage_pkg::*;

module ex_fwd_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic [DATA_W-1:0] rs_fwd,
  output logic [DATA_W-1:0] rt_fwd
);

  fwd_sel_e rs_sel;
  fwd_sel_e rt_sel;

  function automatic fwd_sel_e pick_src(
    input logic [REG_AW-1:0] src,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    fwd_sel_e sel;
    sel = FWD_REGFILE;
    if (src != '0) begin
      if (m_we && (m_rd == src))
        sel = FWD_MEM;
      else if (w_we && (w_rd == src))
        sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    rs_sel = pick_src(rs_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
    rt_sel = pick_src(rt_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
  end

  always_comb begin
    rs_fwd = rs_data;
    case (rs_sel)
      FWD_MEM: rs_fwd = mem_fwd_data;
      FWD_WB:  rs_fwd = wb_fwd_data;
      default: rs_fwd = rs_data;
    endcase
  end

  always_comb begin
    rt_fwd = rt_data;
    case (rt_sel)
      FWD_MEM: rt_fwd = mem_fwd_data;
      FWD_WB:  rt_fwd = wb_fwd_data;
      default: rt_fwd = rt_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// immediate extension and live operand forwarding.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   id_*              : decoded instruction fields from ID
//   mem_*, wb_*       : downstream producers for forwarding
//   flush, ex_hold    : squash entering instruction / freeze EX register
//   id_stall          : ID and IF must hold this cycle
//   ex_*              : EX-stage control and forwarded operands
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_alu_ctr,
  input  logic [4:0]        id_shamt,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic              id_use_imm,
  input  logic              id_imm_zext,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [5:0]        ex_alu_ctr,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_src1,
  output logic [DATA_W-1:0] ex_src2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read
);

  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm_ext;
  logic              r_use_imm;
  logic [DATA_W-1:0] imm_ext;
  logic              hazard;
  logic              bubble;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  always_comb begin
    imm_ext = {{(DATA_W-16){id_imm[15] & ~id_imm_zext}}, id_imm};
  end

  // rt only matters when it is actually an ALU source
  always_comb begin
    hazard = id_valid && ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
             ((ex_rd_addr == id_rs_addr) ||
              (!id_use_imm && (ex_rd_addr == id_rt_addr)));
    bubble = flush || hazard || !id_valid;
    // stall is suppressed while reset is asserted
    id_stall = !rst && (ex_hold || hazard);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_alu_ctr   <= '0;
      ex_shamt     <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm_ext    <= '0;
      r_use_imm    <= 1'b0;
    end else if (!ex_hold) begin
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_alu_ctr   <= '0;
        ex_shamt     <= '0;
        ex_rd_addr   <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        r_rs_addr    <= '0;
        r_rt_addr    <= '0;
        r_rs_data    <= '0;
        r_rt_data    <= '0;
        r_imm_ext    <= '0;
        r_use_imm    <= 1'b0;
      end else begin
        ex_valid     <= 1'b1;
        ex_alu_ctr   <= id_alu_ctr;
        ex_shamt     <= id_shamt;
        ex_rd_addr   <= id_rd_addr;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        r_rs_addr    <= id_rs_addr;
        r_rt_addr    <= id_rt_addr;
        r_rs_data    <= id_rs_data;
        r_rt_data    <= id_rt_data;
        r_imm_ext    <= imm_ext;
        r_use_imm    <= id_use_imm;
      end
    end
  end

  // Forwarding works on the registered source numbers, so held operands
  // keep tracking producers that arrive while ex_hold is asserted.
  ex_fwd_unit #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd (
    .rs_addr       (r_rs_addr),
    .rt_addr       (r_rt_addr),
    .rs_data       (r_rs_data),
    .rt_data       (r_rt_data),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_fwd_data  (mem_fwd_data),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_fwd_data   (wb_fwd_data),
    .rs_fwd        (rs_fwd),
    .rt_fwd        (rt_fwd)
  );

  always_comb begin
    ex_src1       = rs_fwd;
    ex_src2       = r_use_imm ? r_imm_ext : rt_fwd;
    ex_store_data = rt_fwd;
  end

endmodule
